alu_writeback_unit: RTL and testbench

// Execute stage that sits directly downstream of the 16x32 register file.

---
 rtl/alu_wb_if.sv | 30 +++
 rtl/alu_writeback_unit.sv | 157 +++++++++++++++
 tb/tb_alu_writeback_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_if.sv
// Operation request and register-file writeback bundle for alu_writeback_unit.
// The master side issues operations; the slave side (the execute unit) returns
// the writeback strobe, result and status flags.
interface alu_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_sel;
    logic              wb_we;
    logic              busy;
    logic              flag_z;
    logic              flag_c;

    modport master (
        output in_valid, opcode, op_a, op_b, dest,
        input  in_ready, wb_data, wb_sel, wb_we, busy, flag_z, flag_c
    );

    modport slave (
        input  in_valid, opcode, op_a, op_b, dest,
        output in_ready, wb_data, wb_sel, wb_we, busy, flag_z, flag_c
    );
endinterface

// File: rtl/alu_writeback_unit.sv
// Execute stage downstream of the 16x32 register file. Takes two operands, an
// opcode and a destination index, computes the result (single cycle for
// logic/add/shift, iterative shift-add for MUL) and writes it back through a
// one-cycle write strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new operation; in_ready high
// EXEC  | single-cycle op: result computed from latched operands
// MUL   | shift-add multiply, one multiplier bit per cycle, then writeback
// WB    | wb_we high for exactly one cycle with result, dest and flags
module alu_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_wb_if.slave  bus
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [ADDR_W-1:0]  dest_q;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  acc;

    logic [DATA_W-1:0]  wb_data_q;
    logic [ADDR_W-1:0]  wb_sel_q;
    logic               wb_we_q;
    logic               flag_z_q;
    logic               flag_c_q;

    logic [DATA_W:0]    sum_ext;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;

    // Single-cycle ALU on the latched operands; SUB borrow is an unsigned a<b compare
    always_comb begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLL:  alu_res = a_q << b_q[SH_W-1:0];
            OP_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // Sequencer: accept, execute or iterate the multiply, then one writeback cycle.
    // The MUL down-counter runs DATA_W iterations and the writeback is issued on
    // the edge after it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dest_q    <= '0;
            cnt       <= '0;
            acc       <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.opcode;
                        a_q    <= bus.op_a;
                        b_q    <= bus.op_b;
                        dest_q <= bus.dest;
                        acc    <= '0;
                        cnt    <= CNT_W'(DATA_W);
                        state  <= (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_data_q <= alu_res;
                    wb_sel_q  <= dest_q;
                    wb_we_q   <= 1'b1;
                    flag_z_q  <= (alu_res == '0);
                    flag_c_q  <= alu_carry;
                    state     <= S_WB;
                end
                S_MUL: begin
                    if (cnt != '0) begin
                        if (b_q[0]) begin
                            acc <= acc + a_q;
                        end
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        wb_data_q <= acc;
                        wb_sel_q  <= dest_q;
                        wb_we_q   <= 1'b1;
                        flag_z_q  <= (acc == '0);
                        flag_c_q  <= 1'b0;
                        state     <= S_WB;
                    end
                end
                S_WB: begin
                    wb_we_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    wb_we_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst so nothing is offered while reset is being applied
    assign bus.in_ready = !rst && (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_sel   = wb_sel_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.flag_z   = flag_z_q;
    assign bus.flag_c   = flag_c_q;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed-vector bench for alu_writeback_unit with hand-computed results.
module tb_alu_writeback_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_wb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    alu_writeback_unit #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for its writeback, check latency, result and flags,
    // then check that the strobe was a single pulse and the unit is idle again.
    task automatic do_op(input string tag, input logic [2:0] opc,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                         input logic [31:0] exp_data, input logic exp_z, input logic exp_c,
                         input int exp_lat, input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.dest     = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
        check({tag, "_notready_acc"}, 32'(bus.in_ready), 32'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            if (poke && (lat % 2 == 0)) begin
                bus.in_valid = 1'b1;
                bus.opcode   = 3'b000;
                bus.op_a     = 32'h1234_0000 + 32'(lat);
                bus.op_b     = 32'h0000_0055;
                bus.dest     = 4'hF;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            if (bus.wb_we) begin
                seen = 1'b1;
            end else if (poke) begin
                check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
                check({tag, "_notready_run"}, 32'(bus.in_ready), 32'd0);
            end
        end
        check({tag, "_wb_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_wb_sel"}, 32'(bus.wb_sel), 32'(d));
        check({tag, "_wb_data"}, bus.wb_data, exp_data);
        check({tag, "_flag_z"}, 32'(bus.flag_z), 32'(exp_z));
        check({tag, "_flag_c"}, 32'(bus.flag_c), 32'(exp_c));
        @(negedge clk);
        check({tag, "_single_pulse"}, 32'(bus.wb_we), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_data_hold"}, bus.wb_data, exp_data);
    endtask

    initial begin
        int  p1;
        int  p2;
        int  npulse;
        bit  we_seen;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  s1;
        logic [3:0]  s2;

        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.opcode   = 3'b000;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.dest     = '0;

        repeat (3) @(negedge clk);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_wb_sel", 32'(bus.wb_sel), 32'd0);
        check("rst_wb_we", 32'(bus.wb_we), 32'd0);
        check("rst_flag_z", 32'(bus.flag_z), 32'd0);
        check("rst_flag_c", 32'(bus.flag_c), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready_low", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_release", 32'(bus.in_ready), 32'd1);

        //     tag          opc     a             b             d     data          z     c     lat poke
        do_op("add_5_7",    3'b000, 32'd5,        32'd7,        4'd3, 32'd12,       1'b0, 1'b0, 1,  1'b0);
        do_op("add_wrap",   3'b000, 32'hFFFFFFFF, 32'd1,        4'd5, 32'd0,        1'b1, 1'b1, 1,  1'b0);
        do_op("sub_borrow", 3'b001, 32'd3,        32'd5,        4'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 1,  1'b0);

        repeat (3) @(negedge clk);
        check("idle_hold_we", 32'(bus.wb_we), 32'd0);
        check("idle_hold_c", 32'(bus.flag_c), 32'd1);
        check("idle_hold_data", bus.wb_data, 32'hFFFFFFFE);

        do_op("sll_36",     3'b101, 32'd1,        32'd36,       4'd7, 32'h00000010, 1'b0, 1'b0, 1,  1'b0);
        do_op("srl_31",     3'b110, 32'h80000000, 32'd31,       4'd8, 32'h00000001, 1'b0, 1'b0, 1,  1'b0);
        do_op("xor",        3'b100, 32'h0000F0F0, 32'h0000FFFF, 4'd9, 32'h00000F0F, 1'b0, 1'b0, 1,  1'b0);
        do_op("or",         3'b011, 32'h00FF0000, 32'h0000FF00, 4'd10, 32'h00FFFF00, 1'b0, 1'b0, 1, 1'b0);
        do_op("mul",        3'b111, 32'h00010000, 32'h00010001, 4'd11, 32'h00010000, 1'b0, 1'b0, 33, 1'b1);
        do_op("mul_small",  3'b111, 32'd13,       32'd11,       4'd12, 32'd143,      1'b0, 1'b0, 33, 1'b0);
        do_op("sub_zero",   3'b001, 32'd7,        32'd7,        4'd13, 32'd0,        1'b1, 1'b0, 1,  1'b0);

        // Reset in the 10th MUL cycle abandons the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'b111;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd5;
        bus.dest     = 4'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        we_seen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (bus.wb_we) we_seen = 1'b1;
        end
        rst = 1'b1;
        #1;
        check("mrst_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_wb_data", bus.wb_data, 32'd0);
        check("mrst_wb_sel", 32'(bus.wb_sel), 32'd0);
        check("mrst_flag_z", 32'(bus.flag_z), 32'd0);
        rst = 1'b0;
        #1;
        check("mrst_ready_release", 32'(bus.in_ready), 32'd1);
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_we) we_seen = 1'b1;
        end
        check("mrst_no_wb", 32'(we_seen), 32'd0);

        // Back-to-back: in_valid held high across an ADD then an AND.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'b000;
        bus.op_a     = 32'd10;
        bus.op_b     = 32'd20;
        bus.dest     = 4'd4;
        p1 = -1; p2 = -1; npulse = 0;
        d1 = '0; d2 = '0; s1 = '0; s2 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.opcode = 3'b010;
                bus.op_a   = 32'hFF00FF00;
                bus.op_b   = 32'h0FF00FF0;
                bus.dest   = 4'd6;
            end
            if (c == 4) bus.in_valid = 1'b0;
            if (bus.wb_we) begin
                npulse++;
                if (npulse == 1) begin
                    p1 = c; d1 = bus.wb_data; s1 = bus.wb_sel;
                end else if (npulse == 2) begin
                    p2 = c; d2 = bus.wb_data; s2 = bus.wb_sel;
                end
            end
        end
        check("b2b_pulses", 32'(npulse), 32'd2);
        check("b2b_first_at", 32'(p1), 32'd2);
        check("b2b_spacing", 32'(p2 - p1), 32'd3);
        check("b2b_add_data", d1, 32'd30);
        check("b2b_add_sel", 32'(s1), 32'd4);
        check("b2b_and_data", d2, 32'h0F000F00);
        check("b2b_and_sel", 32'(s2), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
